// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: registered fixed-priority / round-robin arbiter with grant locking and RR hold limit
module rr_priority_arbiter #(
    parameter int PORTS    = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PORTS-1:0]         req,
    input  logic                     mode,
    output logic [PORTS-1:0]         gnt,
    output logic                     gnt_valid,
    output logic [$clog2(PORTS)-1:0] gnt_id
);
    localparam int IW = $clog2(PORTS);
    localparam int HW = $clog2(HOLD_MAX + 2);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   rr_ptr, rr_ptr_n, gnt_id_n, win, k;
    logic [HW-1:0]   hold_cnt, hold_cnt_n;
    logic            grant_mode, grant_mode_n, found, expired, keep;
    logic [PORTS-1:0] gnt_n, cand, others;

    // Scan order: identity in fixed mode, rotated from rr_ptr in round-robin mode
    function automatic logic [IW-1:0] scan(input int i, input logic m, input logic [IW-1:0] p);
        return IW'(m ? (int'(p) + i) % PORTS : i);
    endfunction

    // Pick the first candidate in scan order; descending walk lets the earliest hit win
    always_comb begin
        found = |cand;
        win   = '0;
        k     = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            k = scan(i, mode, rr_ptr);
            if (cand[k]) win = k;
        end
    end

    // Next-state: keep the holder, or re-arbitrate (holder masked out on expiry when others wait), or go idle
    always_comb begin
        state_n      = state;
        gnt_n        = gnt;
        gnt_id_n     = gnt_id;
        rr_ptr_n     = rr_ptr;
        hold_cnt_n   = hold_cnt;
        grant_mode_n = grant_mode;
        expired      = grant_mode && (HOLD_MAX != 0) && (int'(hold_cnt) == HOLD_MAX);
        keep         = (|(req & gnt)) && !expired;
        others       = req & ~gnt;
        cand         = (|others) ? others : req;
        if (keep) begin
            hold_cnt_n = (int'(hold_cnt) >= HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);
        end else if (found) begin
            state_n      = GRANT;
            gnt_n        = PORTS'(1) << win;
            gnt_id_n     = win;
            rr_ptr_n     = (int'(win) == PORTS - 1) ? '0 : win + IW'(1);
            hold_cnt_n   = HW'(1);
            grant_mode_n = mode;
        end else begin
            state_n    = IDLE;
            gnt_n      = '0;
            hold_cnt_n = '0;
        end
    end

    // State and output registers; mode is latched at arbitration so a mid-hold change waits for the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            gnt_valid  <= 1'b0;
            gnt_id     <= '0;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
            grant_mode <= 1'b0;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            gnt_valid  <= |gnt_n;
            gnt_id     <= gnt_id_n;
            rr_ptr     <= rr_ptr_n;
            hold_cnt   <= hold_cnt_n;
            grant_mode <= grant_mode_n;
        end
    end
endmodule
